// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  localparam int unsigned DIV_DIVIDEND_W = 26;
  localparam int unsigned DIV_DIVISOR_W  = 18;

  function automatic int unsigned cnt_width(input int unsigned dividend_w);
    return $clog2(dividend_w);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result stream bundle for seq_divider; slave is the divider's view.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = DIV_DIVISOR_W
);

  logic                  s_valid;
  logic                  s_ready;
  logic [DIVIDEND_W-1:0] s_dividend;
  logic [DIVISOR_W-1:0]  s_divisor;
  logic                  m_valid;
  logic                  m_ready;
  logic [DIVIDEND_W-1:0] m_quotient;
  logic [DIVISOR_W-1:0]  m_remainder;
  logic                  m_divzero;

  modport slave (
    input  s_valid, s_dividend, s_divisor, m_ready,
    output s_ready, m_valid, m_quotient, m_remainder, m_divzero
  );

  modport master (
    output s_valid, s_dividend, s_divisor, m_ready,
    input  s_ready, m_valid, m_quotient, m_remainder, m_divzero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module seq_divider_div_step #(
  parameter int unsigned DIVISOR_W = 18
) (
  input  logic [DIVISOR_W-1:0] r_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W-1:0] r_o,
  output logic                 q_o
);

  logic [DIVISOR_W:0] r_shift;

  always_comb begin
    r_shift = {r_i, bit_i};
    q_o     = (r_shift >= {1'b0, divisor_i});
    // The true difference is below the divisor, so wrapping to DIVISOR_W bits is exact.
    r_o     = q_o ? (r_shift[DIVISOR_W-1:0] - divisor_i) : r_shift[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_ROUND_EN to add a round-half-up stage on the quotient.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = DIV_DIVISOR_W
) (
  input  logic         aclk,
  input  logic         areset,
  seq_divider_if.slave div_if
);

  localparam int unsigned CntW = cnt_width(DIVIDEND_W);

  div_state_t            state_q, state_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]  r_q, r_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  divzero_q, divzero_d;

  logic [DIVISOR_W-1:0]  step_r;
  logic                  step_q;

  seq_divider_div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_div_step (
    .r_i       (r_q),
    .bit_i     (dvd_q[cnt_q]),
    .divisor_i (dvs_q),
    .r_o       (step_r),
    .q_o       (step_q)
  );

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    r_d       = r_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    divzero_d = divzero_q;
    unique case (state_q)
      IDLE: begin
        if (div_if.s_valid) begin
          dvd_d = div_if.s_dividend;
          dvs_d = div_if.s_divisor;
          r_d   = '0;
          cnt_d = CntW'(DIVIDEND_W - 1);
          if (div_if.s_divisor == '0) begin
            q_d       = '1;
            divzero_d = 1'b1;
            state_d   = DONE;
          end else begin
            q_d       = '0;
            divzero_d = 1'b0;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        r_d = step_r;
        // Bits resolve MSB first from a cleared quotient, so a left shift lands q[cnt].
        q_d = {q_q[DIVIDEND_W-2:0], step_q};
        if (cnt_q == '0) begin
`ifdef SEQ_DIVIDER_ROUND_EN
          state_d = ROUND;
`else
          state_d = DONE;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef SEQ_DIVIDER_ROUND_EN
      ROUND: begin
        if (({r_q, 1'b0} >= {1'b0, dvs_q}) && (q_q != '1)) begin
          q_d = q_q + 1'b1;
        end
        state_d = DONE;
      end
`endif
      DONE: begin
        if (div_if.m_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      r_q       <= r_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      divzero_q <= divzero_d;
    end
  end

  always_comb begin
    div_if.s_ready     = (state_q == IDLE);
    div_if.m_valid     = (state_q == DONE);
    div_if.m_quotient  = q_q;
    div_if.m_remainder = r_q;
    div_if.m_divzero   = divzero_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int unsigned DW = 26;
  localparam int unsigned VW = 18;
`ifdef SEQ_DIVIDER_ROUND_EN
  localparam int RoundCyc = 1;
`else
  localparam int RoundCyc = 0;
`endif

  logic aclk   = 1'b0;
  logic areset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_divider_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) bus ();

  seq_divider #(
    .DIVIDEND_W (DW),
    .DIVISOR_W  (VW)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .div_if (bus)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Reference: plain integer division plus the round-half-up rule.
  function automatic void model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                output logic [DW-1:0] q, output logic [VW-1:0] r,
                                output logic dz, output int lat);
    longint unsigned qa, ra, qmax;
    qmax = (64'd1 << DW) - 64'd1;
    if (b == '0) begin
      q = '1; r = '0; dz = 1'b1; lat = 1;
    end else begin
      qa = 64'(a) / 64'(b);
      ra = 64'(a) % 64'(b);
      if (RoundCyc == 1 && (2 * ra >= 64'(b)) && qa != qmax) qa = qa + 1;
      q = DW'(qa); r = VW'(ra); dz = 1'b0; lat = DW + 1 + RoundCyc;
    end
  endfunction

  task automatic do_div(input logic [DW-1:0] a, input logic [VW-1:0] b, input int hold,
                        input string name);
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic          edz;
    int            elat, lat, w;
    model(a, b, eq, er, edz, elat);
    w = 0;
    while (bus.s_ready !== 1'b1 && w < 60) begin tick(); w++; end
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_wait: s_ready=%b required 1", name, bus.s_ready);
    end
    bus.s_valid = 1'b1; bus.s_dividend = a; bus.s_divisor = b;
    tick();
    bus.s_valid = 1'b0;
    checks++;
    if (bus.s_ready !== 1'b0) begin
      errors++; $display("FAIL %s busy_ready: s_ready=%b required 0", name, bus.s_ready);
    end
    lat = 1;
    while (bus.m_valid !== 1'b1 && lat < 100) begin tick(); lat++; end
    checks++;
    if (lat != elat) begin
      errors++; $display("FAIL %s latency: got %0d required %0d", name, lat, elat);
    end
    checks++;
    if (bus.m_quotient !== eq || bus.m_remainder !== er || bus.m_divzero !== edz) begin
      errors++;
      $display("FAIL %s result: %0d/%0d got q=%0d r=%0d dz=%b required q=%0d r=%0d dz=%b",
               name, a, b, bus.m_quotient, bus.m_remainder, bus.m_divzero, eq, er, edz);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0 || bus.m_quotient !== eq ||
          bus.m_remainder !== er || bus.m_divzero !== edz) begin
        errors++;
        $display("FAIL %s hold[%0d]: v=%b rdy=%b q=%0d r=%0d required v=1 rdy=0 q=%0d r=%0d",
                 name, i, bus.m_valid, bus.s_ready, bus.m_quotient, bus.m_remainder, eq, er);
      end
    end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    checks++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL %s release: s_ready=%b m_valid=%b required 1/0",
                         name, bus.s_ready, bus.m_valid);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    tick(); tick();
    checks++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0 || bus.m_quotient !== '0 ||
        bus.m_remainder !== '0 || bus.m_divzero !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b v=%b q=%0d r=%0d dz=%b required 1 0 0 0 0", bus.s_ready,
               bus.m_valid, bus.m_quotient, bus.m_remainder, bus.m_divzero);
    end
    areset = 1'b0;
  endtask

  task automatic test_directed();
    do_div(26'd1000, 18'd7, 0, "1000/7");
    do_div(26'd67108863, 18'd1, 0, "max/1");
    do_div(26'd5, 18'd0, 0, "5/0");
    do_div(26'd3, 18'd200, 0, "3/200");
    do_div(26'd90, 18'd9, 0, "90/9");
  endtask

  task automatic test_backpressure();
    bus.m_ready = 1'b0;
    do_div(26'd1000, 18'd7, 10, "bp_1000/7");
    do_div(26'd5, 18'd0, 10, "bp_5/0");
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    bus.s_valid = 1'b1; bus.s_dividend = 26'd1000; bus.s_divisor = 18'd7;
    tick();
    bus.s_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    checks++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0 || bus.m_quotient !== '0 ||
        bus.m_remainder !== '0 || bus.m_divzero !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b v=%b q=%0d r=%0d dz=%b required 1 0 0 0 0", bus.s_ready,
               bus.m_valid, bus.m_quotient, bus.m_remainder, bus.m_divzero);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.m_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL mid_reset_no_result: m_valid seen %0d cycles required 0", seen);
    end
    do_div(26'd90, 18'd9, 0, "post_reset_90/9");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic          edz;
    int            elat, w, gap;
    model(26'd54321, 18'd123, eq, er, edz, elat);
    bus.s_valid = 1'b1; bus.s_dividend = 26'd54321; bus.s_divisor = 18'd123;
    bus.m_ready = 1'b1;
    w = 0;
    while (bus.m_valid !== 1'b1 && w < 100) begin tick(); w++; end
    gap = 0;
    tick();
    while (bus.m_valid !== 1'b1 && gap < 100) begin tick(); gap++; end
    gap++;
    bus.s_valid = 1'b0;
    checks++;
    if (gap != DW + 2 + RoundCyc) begin
      errors++; $display("FAIL b2b_period: got %0d required %0d", gap, DW + 2 + RoundCyc);
    end
    checks++;
    if (bus.m_quotient !== eq || bus.m_remainder !== er || bus.m_divzero !== edz) begin
      errors++; $display("FAIL b2b_result: q=%0d r=%0d required q=%0d r=%0d",
                         bus.m_quotient, bus.m_remainder, eq, er);
    end
    tick();
    bus.m_ready = 1'b0;
    checks++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: s_ready=%b m_valid=%b required 1/0",
                         bus.s_ready, bus.m_valid);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 9))
        0:       b = '0;
        1, 2, 3: b = VW'($urandom_range(1, 15));
        default: b = VW'($urandom_range(1, (1 << VW) - 1));
      endcase
      case ($urandom_range(0, 3))
        0:       a = DW'($urandom_range(0, 1000));
        1:       a = '1;
        default: a = DW'($urandom());
      endcase
      // Idle-time m_ready must not disturb anything.
      bus.m_ready = $urandom_range(0, 1) == 1;
      tick();
      bus.m_ready = 1'b0;
      do_div(a, b, $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    bus.s_valid    = 1'b0;
    bus.s_dividend = '0;
    bus.s_divisor  = '0;
    bus.m_ready    = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
